// File: rtl/result_serializer_pkg.sv
// Shared types and default constants for the compressor result serializer
// and the test harness that drives it.
package result_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    localparam int              DEF_WIDTH = 55;
    localparam int              DEF_SIG_W = 16;
    localparam logic [15:0]     DEF_POLY  = 16'h1021;

    // Bit-counter width: ceil(log2(width)), never narrower than one bit.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/result_serializer_sig_lfsr.sv
// Signature register: folds each accepted serial bit into a running
// CRC-style signature; synchronous clear outranks the fold.
module sig_lfsr
    import result_serializer_pkg::*;
#(
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             bit_in,
    output logic [SIG_W-1:0] sig
);

    logic             feedback;
    logic [SIG_W-1:0] sig_next;

    assign feedback = sig[SIG_W-1] ^ bit_in;
    assign sig_next = {sig[SIG_W-2:0], 1'b0} ^ (feedback ? POLY : '0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/result_serializer.sv
// Snapshots a parallel compressor result and streams it out LSB first with
// valid/ready handshaking, folding every accepted bit into a signature.
module result_serializer
    import result_serializer_pkg::*;
#(
    parameter int               WIDTH = DEF_WIDTH,
    parameter int               SIG_W = DEF_SIG_W,
    parameter logic [SIG_W-1:0] POLY  = DEF_POLY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] dst,
    input  logic             sig_clr,
    input  logic             sout_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy,
    output logic             done,
    output logic             overrun,
    output logic [SIG_W-1:0] signature
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(WIDTH - 1);

    ser_state_t       state;
    ser_state_t       state_next;
    logic [WIDTH-1:0] shadow;
    logic [CNT_W-1:0] cnt;
    logic             at_last;
    logic             beat;
    logic             load;

    assign at_last = (cnt == LAST_COL);
    assign beat    = sout_valid && sout_ready;
    assign load    = (state == IDLE) && capture;

    // Outputs decode straight from registered state so reset clears them
    // without waiting for a clock edge.
    assign sout_valid = (state == SHIFT);
    assign sout_last  = sout_valid && at_last;
    assign sout       = shadow[0];
    assign busy       = (state != IDLE);
    assign done       = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: state_next is defaulted before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (capture) state_next = SHIFT;
            SHIFT:   if (beat && at_last) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The counter stops at the last column, so it never wraps even when
    // WIDTH is an exact power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow <= '0;
            cnt    <= '0;
        end else if (load) begin
            shadow <= dst;
            cnt    <= '0;
        end else if (beat) begin
            shadow <= shadow >> 1;
            if (!at_last) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // A capture that arrives while a frame is still in SHIFT or DONE is lost;
    // remember that until reset so software can tell the result is suspect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (capture && busy) begin
            overrun <= 1'b1;
        end
    end

    sig_lfsr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_sig_lfsr (
        .clk    (clk),
        .rst    (rst),
        .clr    (sig_clr),
        .en     (beat),
        .bit_in (sout),
        .sig    (signature)
    );

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: reset, single-bit frame, signature
// clear, stalled handshake, overrun and mid-frame reset scenarios.
module tb_result_serializer;

    localparam int          W    = 55;
    localparam int          SW   = 16;
    localparam logic [15:0] POLY = 16'h1021;

    logic          clk = 1'b0;
    logic          rst;
    logic          capture;
    logic [W-1:0]  dst;
    logic          sig_clr;
    logic          sout_ready;
    logic          sout;
    logic          sout_valid;
    logic          sout_last;
    logic          busy;
    logic          done;
    logic          overrun;
    logic [SW-1:0] signature;

    int            n_cmp = 0;
    int            n_bad = 0;
    logic [SW-1:0] model = '0;

    always #5 clk = ~clk;

    result_serializer #(.WIDTH(W), .SIG_W(SW), .POLY(POLY)) dut (
        .clk        (clk),
        .rst        (rst),
        .capture    (capture),
        .dst        (dst),
        .sig_clr    (sig_clr),
        .sout_ready (sout_ready),
        .sout       (sout),
        .sout_valid (sout_valid),
        .sout_last  (sout_last),
        .busy       (busy),
        .done       (done),
        .overrun    (overrun),
        .signature  (signature)
    );

    function automatic logic [SW-1:0] sig_step(input logic [SW-1:0] s, input logic b);
        return (s << 1) ^ ((s[SW-1] ^ b) ? POLY : 16'h0000);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Streams one frame and checks every beat; clr_beat / ovr_beat inject a
    // signature clear or a rejected capture at that beat (-1 disables).
    task automatic run_frame(input logic [W-1:0] d, input bit toggle, input int clr_beat,
                             input int ovr_beat, input bit cap_in_done, input string name);
        int   cyc;
        int   beat;
        int   exp_lat;
        bit   stalled;
        bit   clr_now;
        bit   ovr_now;
        logic prev_sout;
        dst = d; capture = 1'b1; sout_ready = 1'b1;
        tick();
        capture = 1'b0;
        cyc = 0; beat = 0; stalled = 0; prev_sout = 1'b0;
        while (beat < W && cyc < 4 * W) begin
            cyc++;
            sout_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            n_cmp++;
            if (sout_valid !== 1'b1 || sout !== d[beat] || sout_last !== (beat == W - 1) || done !== 1'b0) begin
                n_bad++;
                $display("FAIL %s beat %0d: valid=%b sout=%b last=%b done=%b, required 1 %b %b 0",
                         name, beat, sout_valid, sout, sout_last, done, d[beat], (beat == W - 1));
            end
            if (stalled) begin
                n_cmp++;
                if (sout !== prev_sout) begin
                    n_bad++;
                    $display("FAIL %s hold beat %0d: sout=%b, required %b", name, beat, sout, prev_sout);
                end
            end
            clr_now = (beat == clr_beat) && sout_ready;
            ovr_now = (beat == ovr_beat);
            if (clr_now) sig_clr = 1'b1;
            if (ovr_now) begin capture = 1'b1; dst = ~d; end
            if (sout_ready) begin
                model = clr_now ? '0 : sig_step(model, d[beat]);
                beat++;
            end
            stalled = !sout_ready;
            prev_sout = sout;
            tick();
            capture = 1'b0; sig_clr = 1'b0;
            if (clr_now) begin
                n_cmp++;
                if (signature !== '0) begin
                    n_bad++;
                    $display("FAIL %s clr priority: signature=%h, required 0000", name, signature);
                end
            end
            if (ovr_now) begin
                n_cmp++;
                if (overrun !== 1'b1) begin
                    n_bad++;
                    $display("FAIL %s overrun set: overrun=%b, required 1", name, overrun);
                end
            end
        end
        exp_lat = toggle ? 2 * W - 1 : W;
        n_cmp++;
        if (cyc !== exp_lat || done !== 1'b1 || busy !== 1'b1 || sout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s done: latency=%0d done=%b busy=%b valid=%b, required %0d 1 1 0",
                     name, cyc, done, busy, sout_valid, exp_lat);
        end
        n_cmp++;
        if (signature !== model) begin
            n_bad++;
            $display("FAIL %s signature: got %h, required %h", name, signature, model);
        end
        if (cap_in_done) begin
            capture = 1'b1; dst = ~d;
        end
        tick();
        capture = 1'b0;
        n_cmp++;
        if (done !== 1'b0 || busy !== 1'b0 || sout_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s after done: done=%b busy=%b valid=%b, required 0 0 0",
                     name, done, busy, sout_valid);
        end
        if (cap_in_done) begin
            n_cmp++;
            if (overrun !== 1'b1) begin
                n_bad++;
                $display("FAIL %s capture in DONE: overrun=%b, required 1", name, overrun);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; capture = 1'b0; sig_clr = 1'b0; sout_ready = 1'b0; dst = '0;
        #3;
        n_cmp++;
        if ({sout, sout_valid, sout_last, busy, done, overrun} !== 6'b0 || signature !== '0) begin
            n_bad++;
            $display("FAIL reset: outs=%b sig=%h, required 000000 0000",
                     {sout, sout_valid, sout_last, busy, done, overrun}, signature);
        end
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b0 || signature !== '0) begin
            n_bad++;
            $display("FAIL idle after reset: busy=%b sig=%h, required 0 0000", busy, signature);
        end
        model = '0;
    endtask

    task automatic test_single_bit();
        run_frame(55'h1, 1'b0, -1, -1, 1'b0, "single_bit");
    endtask

    task automatic test_sig_clr();
        sig_clr = 1'b1;
        tick();
        sig_clr = 1'b0;
        model = '0;
        n_cmp++;
        if (signature !== 16'h0000) begin
            n_bad++;
            $display("FAIL sig_clr idle: signature=%h, required 0000", signature);
        end
        run_frame('0, 1'b0, -1, -1, 1'b0, "zero_frame");
        n_cmp++;
        if (signature !== 16'h0000) begin
            n_bad++;
            $display("FAIL zero frame signature: got %h, required 0000", signature);
        end
        run_frame(55'h1, 1'b0, -1, -1, 1'b0, "one_after_clr");
        n_cmp++;
        if (signature === 16'h0000) begin
            n_bad++;
            $display("FAIL one frame signature: got %h, required nonzero", signature);
        end
        run_frame(55'h7, 1'b0, 1, -1, 1'b0, "clr_priority");
    endtask

    task automatic test_stall();
        run_frame(55'h2AAAAAAAAAAAAA, 1'b0, -1, -1, 1'b0, "pattern_ready");
        run_frame(55'h2AAAAAAAAAAAAA, 1'b1, -1, -1, 1'b0, "pattern_stall");
    endtask

    task automatic test_overrun();
        n_cmp++;
        if (overrun !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun before: overrun=%b, required 0", overrun);
        end
        run_frame(55'h0F0F0F0F0F0F0F, 1'b0, -1, 10, 1'b1, "overrun");
        tick();
        tick();
        n_cmp++;
        if (overrun !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun sticky: overrun=%b busy=%b, required 1 0", overrun, busy);
        end
    endtask

    task automatic test_back_to_back();
        run_frame(55'h5A5A5A5A5A5A5A, 1'b0, -1, -1, 1'b0, "b2b_a");
        run_frame(55'h123456789ABCDE, 1'b0, -1, -1, 1'b0, "b2b_b");
    endtask

    task automatic test_reset_mid();
        int done_seen;
        dst = 55'h3FFFFFFFFFFFFF; capture = 1'b1; sout_ready = 1'b1;
        tick();
        capture = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({sout, sout_valid, sout_last, busy, done, overrun} !== 6'b0 || signature !== '0) begin
            n_bad++;
            $display("FAIL async reset: outs=%b sig=%h, required 000000 0000",
                     {sout, sout_valid, sout_last, busy, done, overrun}, signature);
        end
        tick();
        rst = 1'b0;
        model = '0;
        done_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (done === 1'b1 || busy === 1'b1) done_seen++;
            tick();
        end
        n_cmp++;
        if (done_seen !== 0) begin
            n_bad++;
            $display("FAIL abandoned frame: %0d busy/done cycles, required 0", done_seen);
        end
        run_frame(55'h1, 1'b0, -1, -1, 1'b0, "after_reset");
        n_cmp++;
        if (signature !== sig_step(16'h0000, 1'b1) << 54 && signature !== model) begin
            n_bad++;
            $display("FAIL clean frame signature: got %h, required %h", signature, model);
        end
    endtask

    initial begin
        test_reset();
        test_single_bit();
        test_sig_clr();
        test_stall();
        test_back_to_back();
        test_overrun();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
